minmax_tracker: RTL and testbench



---
 rtl/minmax_tracker_pkg.sv | 21 ++
 rtl/comparator_8bit.sv | 26 ++
 rtl/minmax_tracker.sv | 171 +++++++++++++++++
 tb/tb_minmax_tracker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/minmax_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minmax_tracker_pkg
// Description : Shared types and constants for the frame min/max tracker:
//               controller state encoding and the default sample width.
// Revision    : 1.0 - initial release
// ============================================================================
package minmax_tracker_pkg;

    // Default sample width used when the instantiating level does not override it
    localparam int c_DEFAULT_DATA_WIDTH = 8;

    // Frame controller states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

endpackage : minmax_tracker_pkg
`default_nettype wire

// File: rtl/comparator_8bit.sv
`default_nettype none
// ============================================================================
// Module      : comparator_8bit
// Description : Unsigned magnitude comparator. Produces a > b, a < b and
//               a == b flags for operands of DATA_WIDTH bits (8 by default).
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_8bit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_gt,
    output logic                  o_lt,
    output logic                  o_eq
);

    // Pure combinational unsigned compare
    always_comb begin
        o_gt = (i_a >  i_b);
        o_lt = (i_a <  i_b);
        o_eq = (i_a == i_b);
    end

endmodule : comparator_8bit
`default_nettype wire

// File: rtl/minmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : minmax_tracker
// Description : Streams a frame of FRAME_LEN unsigned samples through two
//               shared magnitude comparators, tracking running maximum and
//               minimum with the index of their first occurrence. The frame
//               result is offered on a valid/ready handshake and held stable
//               until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter  int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter  int FRAME_LEN  = 16,
    localparam int IDX_W      = $clog2(FRAME_LEN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic [DATA_WIDTH-1:0] o_min,
    output logic [IDX_W-1:0]      o_max_idx,
    output logic [IDX_W-1:0]      o_min_idx,
    output logic                  o_flat,
    output logic                  o_busy
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] c_ONE      = IDX_W'(1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_count;
    logic [DATA_WIDTH-1:0]   r_max;
    logic [DATA_WIDTH-1:0]   r_min;
    logic [IDX_W-1:0]        r_max_idx;
    logic [IDX_W-1:0]        r_min_idx;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_flat;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_a_gt;
    logic                    w_a_lt;
    logic                    w_a_eq;
    logic                    w_b_gt;
    logic                    w_b_lt;
    logic                    w_b_eq;
    logic                    w_unused_cmp;

    // Comparator A: new sample against the running maximum
    comparator_8bit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp_max (
        .i_a  (i_data),
        .i_b  (r_max),
        .o_gt (w_a_gt),
        .o_lt (w_a_lt),
        .o_eq (w_a_eq)
    );

    // Comparator B: new sample against the running minimum
    comparator_8bit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp_min (
        .i_a  (i_data),
        .i_b  (r_min),
        .o_gt (w_b_gt),
        .o_lt (w_b_lt),
        .o_eq (w_b_eq)
    );

    // Only the gt of A and lt of B drive updates; the opposite flags are spare
    assign w_unused_cmp = w_a_lt | w_b_gt;

    // Ready is decoded from state and forced low while reset is asserted
    always_comb begin
        o_ready  = ~i_rst & (r_state != HOLD);
        w_accept = i_valid & o_ready;
        w_last   = (r_count == c_LAST_IDX);
    end

    // Frame controller, sample counter and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_flat    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_max     <= i_data;
                        r_min     <= i_data;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_count   <= c_ONE;
                        r_busy    <= 1'b1;
                        r_state   <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (w_accept) begin
                        // Strict compares: ties keep the earliest index
                        if (w_a_gt) begin
                            r_max     <= i_data;
                            r_max_idx <= r_count;
                        end
                        if (w_b_lt) begin
                            r_min     <= i_data;
                            r_min_idx <= r_count;
                        end
                        if (w_last) begin
                            // Final max equals final min exactly when the last
                            // sample matches both running extremes; the counter
                            // parks at its last index until the result is taken.
                            r_flat  <= w_a_eq & w_b_eq;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= HOLD;
                        end else begin
                            r_count <= r_count + c_ONE;
                        end
                    end
                end

                HOLD: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_count <= '0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_max     = r_max;
    assign o_min     = r_min;
    assign o_max_idx = r_max_idx;
    assign o_min_idx = r_min_idx;
    assign o_flat    = r_flat;

    // Handshake and counter invariants
    a_valid_ready_excl : assert property (@(posedge i_clk) !(o_valid && o_ready));
    a_busy_valid_excl  : assert property (@(posedge i_clk) !(o_busy && o_valid));
    a_count_range      : assert property (@(posedge i_clk) r_count <= c_LAST_IDX);

endmodule : minmax_tracker
`default_nettype wire

// File: tb/tb_minmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_minmax_tracker
// Description : Self-checking bench for minmax_tracker (FRAME_LEN=4,
//               DATA_WIDTH=8). Directed frames plus randomized frames with
//               random input gaps and result backpressure, checked against a
//               behavioural frame-statistics model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_minmax_tracker;

    localparam int c_DW = 8;
    localparam int c_FL = 4;
    localparam int c_IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [c_DW-1:0] in_data;
    logic            in_ready;
    logic            o_ready;
    logic            o_valid;
    logic [c_DW-1:0] o_max;
    logic [c_DW-1:0] o_min;
    logic [c_IW-1:0] o_max_idx;
    logic [c_IW-1:0] o_min_idx;
    logic            o_flat;
    logic            o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [c_DW-1:0] smp [c_FL];
    int e_max, e_min, e_maxi, e_mini, e_flat;

    minmax_tracker #(
        .DATA_WIDTH (c_DW),
        .FRAME_LEN  (c_FL)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (in_valid),
        .i_data    (in_data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .i_ready   (in_ready),
        .o_max     (o_max),
        .o_min     (o_min),
        .o_max_idx (o_max_idx),
        .o_min_idx (o_min_idx),
        .o_flat    (o_flat),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame statistics straight from the definition: first index of max/min, all-equal flag
    task automatic model();
        e_max = 0;  e_maxi = 0;
        e_min = 256; e_mini = 0;
        e_flat = 1;
        for (int i = 0; i < c_FL; i++) begin
            if (int'(smp[i]) > e_max || i == 0) begin
                if (i == 0 || int'(smp[i]) > e_max) begin e_max = int'(smp[i]); e_maxi = i; end
            end
            if (int'(smp[i]) < e_min) begin e_min = int'(smp[i]); e_mini = i; end
            if (smp[i] != smp[0]) e_flat = 0;
        end
    endtask

    task automatic check_result(input string pfx);
        check({pfx, "_max"},     32'(o_max),     32'(e_max));
        check({pfx, "_min"},     32'(o_min),     32'(e_min));
        check({pfx, "_max_idx"}, 32'(o_max_idx), 32'(e_maxi));
        check({pfx, "_min_idx"}, 32'(o_min_idx), 32'(e_mini));
        check({pfx, "_flat"},    32'(o_flat),    32'(e_flat));
    endtask

    // Feed smp[] with up to max_gap idle cycles before each sample, then hold the result hold_cycles
    task automatic run_frame(input int max_gap, input int hold_cycles);
        model();
        in_ready = (hold_cycles == 0);
        for (int i = 0; i < c_FL; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
                if (i > 0) check("busy_gap", 32'(o_busy), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = smp[i];
            check("ready_accum", 32'(o_ready), 32'd1);
            tick();
            if (i < c_FL - 1) begin
                check("busy_frame",  32'(o_busy),  32'd1);
                check("valid_early", 32'(o_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("latency_valid", 32'(o_valid), 32'd1);
        check("busy_done",     32'(o_busy),  32'd0);
        check("ready_hold",    32'(o_ready), 32'd0);
        check_result("res");
        for (int k = 0; k < hold_cycles; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check_result("bp");
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        check("released_valid", 32'(o_valid), 32'd0);
        check("released_ready", 32'(o_ready), 32'd1);
        check_result("idle_keep");
    endtask

    task automatic set_frame(input int a, input int b, input int c, input int d);
        smp[0] = 8'(a); smp[1] = 8'(b); smp[2] = 8'(c); smp[3] = 8'(d);
    endtask

    task automatic check_reset_values();
        check("rst_valid",   32'(o_valid),   32'd0);
        check("rst_busy",    32'(o_busy),    32'd0);
        check("rst_max",     32'(o_max),     32'd0);
        check("rst_min",     32'(o_min),     32'd0);
        check("rst_max_idx", 32'(o_max_idx), 32'd0);
        check("rst_min_idx", 32'(o_min_idx), 32'd0);
        check("rst_flat",    32'(o_flat),    32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_data  = '0;
        tick();
        tick();
        check_reset_values();
        check("rst_ready_low", 32'(o_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(o_ready), 32'd1);

        // Distinct values, back-to-back
        set_frame(10, 200, 3, 77);   run_frame(0, 0);
        // Ties keep the earliest index
        set_frame(5, 9, 9, 5);       run_frame(0, 0);
        // Flat frames at both extremes
        set_frame(255, 255, 255, 255); run_frame(0, 0);
        set_frame(0, 0, 0, 0);       run_frame(0, 0);
        // Backpressure then the next frame
        set_frame(7, 100, 100, 7);   run_frame(0, 3);
        set_frame(1, 2, 3, 4);       run_frame(0, 0);
        // Gappy input
        set_frame(10, 200, 3, 77);   run_frame(2, 0);

        // Abort after two accepted samples
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        tick();
        in_data  = 8'd1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check_reset_values();
        check("rst_mid_ready", 32'(o_ready), 32'd0);
        rst = 1'b0;
        #1;
        set_frame(50, 40, 60, 45);   run_frame(0, 0);

        // Randomized frames: mix of narrow-range values (ties/flat) and full range
        for (int f = 0; f < 24; f++) begin
            logic narrow;
            narrow = 1'($urandom_range(0, 1));
            for (int i = 0; i < c_FL; i++)
                smp[i] = narrow ? 8'($urandom_range(0, 2)) : 8'($urandom);
            run_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_minmax_tracker
`default_nettype wire
